// File: rtl/clock_pkg.sv
// Shared types and BCD constants for the 12-hour wall clock and its alarm stage.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_e;

  localparam logic [7:0] HH_RESET     = 8'h12;
  localparam logic [7:0] MAX_MIN      = 8'h59;
  localparam logic [7:0] MAX_HH       = 8'h12;
  localparam logic [7:0] MIN_HH       = 8'h01;
  localparam int         SECS_PER_MIN = 60;

endpackage

// File: rtl/bcd_time_check.sv
// Combinational 12-hour BCD hour (01..12) and minute (00..59) validity check.
// Zero latency, no flow control; usable by any stage that loads a time value.
module bcd_time_check (
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  output logic       hh_ok,
  output logic       mm_ok
);
  import clock_pkg::*;

  // Range compare alone would let hex digits such as 8'h0A through.
  assign hh_ok = (hh >= MIN_HH) && (hh <= MAX_HH) && (hh[3:0] <= 4'd9);
  assign mm_ok = (mm <= MAX_MIN) && (mm[3:0] <= 4'd9);

endmodule

// File: rtl/wall_clock_alarm.sv
// Alarm stage behind the 12-hour BCD wall clock: ring rises one cycle after the match cycle; no backpressure.
// Snooze/timeout timed in ena ticks; optional WALL_CLOCK_ALARM_SNOOZE_LIMIT_EN caps snoozes at three.
module wall_clock_alarm #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  input  logic       arm,
  input  logic       set_alarm,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic       set_pm,
  input  logic       snooze,
  input  logic       stop,
  output logic [7:0] al_hh,
  output logic [7:0] al_mm,
  output logic       al_pm,
  output logic       ring,
  output logic       snoozing,
  output logic       set_err
);
  import clock_pkg::*;

  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNOOZE_MIN * SECS_PER_MIN + 1);
  localparam logic [RW-1:0] RING_TERM = RW'(RING_SECS);
  localparam logic [SW-1:0] SNZ_TERM  = SW'(SNOOZE_MIN * SECS_PER_MIN);

  alarm_state_e  state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d, ring_inc;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d, snz_inc;
  logic [7:0]    al_hh_q, al_hh_d, al_mm_q, al_mm_d;
  logic          al_pm_q, al_pm_d;
  logic          match_q, match_d;
  logic          ring_q, ring_d, snoozing_q, snoozing_d, set_err_q, set_err_d;
  logic          hh_ok, mm_ok, set_ok, trigger, snz_ok;

`ifdef WALL_CLOCK_ALARM_SNOOZE_LIMIT_EN
  logic [1:0] snz_used_q, snz_used_d;
`endif

  bcd_time_check u_check (
    .hh    (set_hh),
    .mm    (set_mm),
    .hh_ok (hh_ok),
    .mm_ok (mm_ok)
  );

  always_comb begin
    match_d = arm && (hh == al_hh_q) && (mm == al_mm_q) && (pm == al_pm_q) && (ss == 8'h00);
    // Edge-detect so a whole matching minute yields a single trigger.
    trigger   = match_d && !match_q;
    set_ok    = set_alarm && hh_ok && mm_ok;
    set_err_d = set_alarm && !(hh_ok && mm_ok);
    ring_inc  = (ring_cnt_q == RING_TERM) ? ring_cnt_q : ring_cnt_q + RW'(1);
    snz_inc   = (snz_cnt_q == SNZ_TERM) ? snz_cnt_q : snz_cnt_q + SW'(1);
`ifdef WALL_CLOCK_ALARM_SNOOZE_LIMIT_EN
    snz_ok = (snz_used_q != 2'd3);
`else
    snz_ok = 1'b1;
`endif

    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    al_hh_d    = al_hh_q;
    al_mm_d    = al_mm_q;
    al_pm_d    = al_pm_q;

    if (set_ok) begin
      al_hh_d = set_hh;
      al_mm_d = set_mm;
      al_pm_d = set_pm;
      state_d = IDLE;
    end else if (!arm) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_d    = RING;
            ring_cnt_d = '0;
          end
        end
        RING: begin
          if (stop) begin
            state_d = IDLE;
          end else if (snooze && snz_ok) begin
            state_d   = SNOOZE;
            snz_cnt_d = '0;
          end else if (ena) begin
            ring_cnt_d = ring_inc;
            if (ring_inc == RING_TERM) state_d = IDLE;
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d = IDLE;
          end else if (ena) begin
            snz_cnt_d = snz_inc;
            if (snz_inc == SNZ_TERM) begin
              state_d    = RING;
              ring_cnt_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef WALL_CLOCK_ALARM_SNOOZE_LIMIT_EN
    snz_used_d = snz_used_q;
    if (state_q == RING && state_d == SNOOZE) snz_used_d = snz_used_q + 2'd1;
    if (state_d == IDLE) snz_used_d = '0;
`endif

    ring_d     = (state_d == RING);
    snoozing_d = (state_d == SNOOZE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      al_hh_q    <= HH_RESET;
      al_mm_q    <= 8'h00;
      al_pm_q    <= 1'b0;
      match_q    <= 1'b0;
      ring_q     <= 1'b0;
      snoozing_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      al_hh_q    <= al_hh_d;
      al_mm_q    <= al_mm_d;
      al_pm_q    <= al_pm_d;
      match_q    <= match_d;
      ring_q     <= ring_d;
      snoozing_q <= snoozing_d;
      set_err_q  <= set_err_d;
    end
  end

`ifdef WALL_CLOCK_ALARM_SNOOZE_LIMIT_EN
  always_ff @(posedge clk) begin
    if (reset) snz_used_q <= '0;
    else       snz_used_q <= snz_used_d;
  end
`endif

  assign al_hh    = al_hh_q;
  assign al_mm    = al_mm_q;
  assign al_pm    = al_pm_q;
  assign ring     = ring_q;
  assign snoozing = snoozing_q;
  assign set_err  = set_err_q;

endmodule

// File: tb/tb_wall_clock_alarm.sv
// Directed bench for wall_clock_alarm: drives a seconds-of-day wall clock and checks against a countdown model.
module tb_wall_clock_alarm;
  localparam int RS = 60;
  localparam int SM = 9;
  localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1, ena = 1'b0, pm = 1'b0, arm = 1'b0;
  logic [7:0] hh = 8'h12, mm = 8'h00, ss = 8'h00;
  logic       set_alarm = 1'b0, set_pm = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic [7:0] set_hh = 8'h00, set_mm = 8'h00;
  logic [7:0] al_hh, al_mm;
  logic       al_pm, ring, snoozing, set_err;

  int total = 0;
  int bad   = 0;
  int tod   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  wall_clock_alarm #(.RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
    .clk(clk), .reset(reset), .ena(ena), .hh(hh), .mm(mm), .ss(ss), .pm(pm),
    .arm(arm), .set_alarm(set_alarm), .set_hh(set_hh), .set_mm(set_mm), .set_pm(set_pm),
    .snooze(snooze), .stop(stop), .al_hh(al_hh), .al_mm(al_mm), .al_pm(al_pm),
    .ring(ring), .snoozing(snoozing), .set_err(set_err)
  );

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic show();
    int h24, h12;
    h24 = tod / 3600;
    h12 = h24 % 12;
    if (h12 == 0) h12 = 12;
    hh = to_bcd(h12);
    mm = to_bcd((tod / 60) % 60);
    ss = to_bcd(tod % 60);
    pm = (h24 >= 12);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining-tick countdowns rather than up-counters.
  int         m_mode = M_IDLE, m_left = 0, m_used = 0;
  bit         m_prev = 1'b0, m_err = 1'b0, m_pm = 1'b0;
  logic [7:0] m_hh = 8'h12, m_mm = 8'h00;
  int         t_h, t_m;
  bit         t_ok, t_hit, t_trig, t_allow;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = M_IDLE; m_left = 0; m_used = 0; m_prev = 1'b0;
      m_hh = 8'h12; m_mm = 8'h00; m_pm = 1'b0; m_err = 1'b0;
    end else begin
      t_h  = from_bcd(set_hh);
      t_m  = from_bcd(set_mm);
      t_ok = (t_h >= 1) && (t_h <= 12) && (t_m >= 0) && (t_m <= 59);
      t_hit  = arm && (hh == m_hh) && (mm == m_mm) && (pm == m_pm) && (ss == 8'h00);
      t_trig = t_hit && !m_prev;
      m_prev = t_hit;
      m_err  = set_alarm && !t_ok;
`ifdef WALL_CLOCK_ALARM_SNOOZE_LIMIT_EN
      t_allow = (m_used < 3);
`else
      t_allow = 1'b1;
`endif
      if (set_alarm && t_ok) begin
        m_hh = set_hh; m_mm = set_mm; m_pm = set_pm; m_mode = M_IDLE;
      end else if (!arm) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_RING) begin
        if (stop) m_mode = M_IDLE;
        else if (snooze && t_allow) begin
          m_mode = M_SNZ; m_left = SM * 60; m_used++;
        end else if (ena) begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end else if (m_mode == M_SNZ) begin
        if (stop) m_mode = M_IDLE;
        else if (ena) begin
          m_left--;
          if (m_left == 0) begin m_mode = M_RING; m_left = RS; end
        end
      end else if (t_trig) begin
        m_mode = M_RING; m_left = RS;
      end
      if (m_mode == M_IDLE) m_used = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("ring",     {7'd0, ring},     {7'd0, m_mode == M_RING});
      check("snoozing", {7'd0, snoozing}, {7'd0, m_mode == M_SNZ});
      check("set_err",  {7'd0, set_err},  {7'd0, m_err});
      check("al_hh", al_hh, m_hh);
      check("al_mm", al_mm, m_mm);
      check("al_pm", {7'd0, al_pm}, {7'd0, m_pm});
    end
  end

  // One clock cycle; pulses last exactly this cycle and the wall clock advances on an ena edge.
  task automatic cyc(input bit e);
    ena = e;
    @(negedge clk);
    if (e) begin
      tod = (tod + 1) % 86400;
      show();
    end
    ena = 1'b0; set_alarm = 1'b0; snooze = 1'b0; stop = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin cyc(1'b1); cyc(1'b0); end
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input bit p);
    set_hh = h; set_mm = m; set_pm = p; set_alarm = 1'b1;
    cyc(1'b0);
  endtask

  task automatic ring_at_next_tick(input int start);
    tod = start; show();
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b0);
  endtask

  // Counts ena ticks until ring reaches the wanted level; returns -1 when the bound expires.
  task automatic ticks_until(input bit lvl, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      cyc(1'b1);
      if (ring == lvl) begin n = i; break; end
      cyc(1'b0);
    end
  endtask

  initial begin
    int n;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    show();
    @(negedge clk);
    chk_on = 1'b1;
    cyc(1'b0);
    reset = 1'b0;
    check("rst_al_hh", al_hh, 8'h12);
    check("rst_al_mm", al_mm, 8'h00);
    check("rst_ring", {7'd0, ring}, 8'h00);

    arm = 1'b1;
    load(8'h06, 8'h30, 1'b0);
    check("set_al_hh", al_hh, 8'h06);
    check("set_al_mm", al_mm, 8'h30);

    tod = 6 * 3600 + 29 * 60 + 58; show();
    cyc(1'b0);
    ticks(1);
    cyc(1'b1);
    check("match_cycle_ring", {7'd0, ring}, 8'h00);
    cyc(1'b0);
    check("ring_rise", {7'd0, ring}, 8'h01);
    ticks_until(1'b0, 100, n);
    check("timeout_ticks", 8'(n), 8'd60);
    cyc(1'b0);
    ticks(30);

    tod = 18 * 3600 + 29 * 60 + 58; show();
    ticks(4);
    check("pm_no_ring", {7'd0, ring}, 8'h00);

    ring_at_next_tick(6 * 3600 + 29 * 60 + 59);
    check("ring_again", {7'd0, ring}, 8'h01);
    ticks(3);
    snooze = 1'b1; cyc(1'b0);
    check("snz_state", {7'd0, snoozing}, 8'h01);
    check("snz_ring", {7'd0, ring}, 8'h00);
    ticks_until(1'b1, 600, n);
    check("snooze_ticks", 8'(n / 4), 8'(540 / 4));
    check("snooze_ticks_lo", 8'(n % 256), 8'(540 % 256));
    cyc(1'b0);
    stop = 1'b1; cyc(1'b0);
    check("stop_ring", {7'd0, ring}, 8'h00);
    check("stop_snz", {7'd0, snoozing}, 8'h00);

    load(8'h13, 8'h30, 1'b0);
    check("err_hh13", {7'd0, set_err}, 8'h01);
    cyc(1'b0);
    check("err_pulse_end", {7'd0, set_err}, 8'h00);
    load(8'h06, 8'h5A, 1'b0);
    check("err_mm5a", {7'd0, set_err}, 8'h01);
    load(8'h00, 8'h30, 1'b0);
    check("err_hh00", {7'd0, set_err}, 8'h01);
    check("err_keep_hh", al_hh, 8'h06);
    check("err_keep_mm", al_mm, 8'h30);

    load(8'h12, 8'h00, 1'b0);
    ring_at_next_tick(86399);
    check("midnight_ring", {7'd0, ring}, 8'h01);
    stop = 1'b1; snooze = 1'b1; cyc(1'b0);
    check("stop_wins_ring", {7'd0, ring}, 8'h00);
    check("stop_wins_snz", {7'd0, snoozing}, 8'h00);

    ring_at_next_tick(86399);
    snooze = 1'b1; cyc(1'b0);
    ticks(2);
    arm = 1'b0; cyc(1'b0);
    check("arm_drop_snz", {7'd0, snoozing}, 8'h00);
    tod = 0; show();
    cyc(1'b0);
    arm = 1'b1; cyc(1'b0);
    cyc(1'b0);
    check("rearm_trigger", {7'd0, ring}, 8'h01);
    stop = 1'b1; cyc(1'b0);

    ring_at_next_tick(86399);
    for (int k = 0; k < 3; k++) begin
      snooze = 1'b1; cyc(1'b0);
      ticks_until(1'b1, 600, n);
      check("limit_snooze_len", 8'(n % 256), 8'(540 % 256));
      cyc(1'b0);
    end
    snooze = 1'b1; cyc(1'b0);
`ifdef WALL_CLOCK_ALARM_SNOOZE_LIMIT_EN
    check("fourth_snooze_ring", {7'd0, ring}, 8'h01);
`else
    check("fourth_snooze_snz", {7'd0, snoozing}, 8'h01);
`endif
    stop = 1'b1; cyc(1'b0);
    check("final_idle", {7'd0, ring | snoozing}, 8'h00);

    reset = 1'b1; cyc(1'b0);
    reset = 1'b0;
    check("reset_al_hh", al_hh, 8'h12);
    cyc(1'b0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wall_clock_alarm.md
Name: wall_clock_alarm

Overview:
- Alarm stage directly downstream of the 12-hour BCD wall clock.
- Consumes the clock's hh/mm/ss/pm and its 1 Hz `ena` tick.
- Stores a programmable alarm time and raises `ring` when the clock reaches it.
- Provides snooze, stop and auto-timeout, all timed by counting `ena` ticks.

Parameters:
- RING_SECS, 60: `ena` ticks `ring` stays high before auto-stop (1..255).
- SNOOZE_MIN, 9: snooze length in minutes; snooze period = SNOOZE_MIN*60 `ena` ticks (1..59).

Ports:
- clk  in  1  system clock, same as wall clock
- reset  in  1  synchronous, active-high
- ena  in  1  1 Hz tick, same signal that advances the wall clock
- hh  in  8  clock hours, packed BCD 01..12
- mm  in  8  clock minutes, packed BCD 00..59
- ss  in  8  clock seconds, packed BCD 00..59
- pm  in  1  clock AM(0)/PM(1)
- arm  in  1  level; alarm enabled when high
- set_alarm  in  1  pulse; load alarm time from set_hh/set_mm/set_pm
- set_hh  in  8  new alarm hours, BCD
- set_mm  in  8  new alarm minutes, BCD
- set_pm  in  1  new alarm AM/PM
- snooze  in  1  pulse
- stop  in  1  pulse
- al_hh  out  8  stored alarm hours
- al_mm  out  8  stored alarm minutes
- al_pm  out  1  stored alarm AM/PM
- ring  out  1  alarm sounding
- snoozing  out  1  high in SNOOZE state
- set_err  out  1  one-cycle pulse on rejected set_alarm

Behaviour:
- Reset values:
  - al_hh=8'h12, al_mm=8'h00, al_pm=0.
  - ring=0, snoozing=0, set_err=0.
  - State IDLE; all counters 0; match_q=0.
- Loading the alarm:
  - set_alarm accepted only if set_hh ∈ {01..09,10,11,12} BCD and set_mm is valid BCD 00..59 (each nibble ≤9, tens ≤5).
  - Accepted: registers update on the next edge.
  - Rejected: registers unchanged, set_err=1 for one cycle.
  - An accepted set_alarm forces state to IDLE from any state.
- Match detection:
  - match = arm & (hh==al_hh) & (mm==al_mm) & (pm==al_pm) & (ss==8'h00), evaluated every cycle.
  - match_q registers match.
  - Trigger = match & ~match_q, so there is exactly one trigger per alarm minute.
- FSM states: IDLE, RING, SNOOZE. Outputs are registered: ring=(state==RING), snoozing=(state==SNOOZE).
- IDLE:
  - trigger -> RING; ring_cnt cleared.
  - ring rises 1 cycle after the cycle in which the clock shows al_hh:al_mm:00 with matching pm.
- RING:
  - ring_cnt increments on each `ena`.
  - stop -> IDLE.
  - snooze (without stop) -> SNOOZE; snz_cnt cleared.
  - ring_cnt reaching RING_SECS on an `ena` -> IDLE.
- SNOOZE:
  - snz_cnt increments on each `ena`.
  - Reaching SNOOZE_MIN*60 -> RING; ring_cnt cleared.
  - stop -> IDLE. snooze is ignored.
- Any state: arm=0 -> IDLE next cycle. Re-raising arm does not re-trigger inside the same minute unless match transitions from 0 to 1.
- Priority (highest first): reset, accepted set_alarm, arm low, stop, snooze, counter expiry, trigger.
- Trigger while in RING or SNOOZE is ignored.
- Counter widths:
  - ring_cnt: $clog2(RING_SECS+1).
  - snz_cnt: $clog2(SNOOZE_MIN*60+1).
  - Neither counter wraps; each saturates at its terminal value.
- 12 o'clock handling: 12:xx AM and 12:xx PM are distinct alarms; comparison is exact on pm.
- Reset mid-ring or mid-snooze returns everything to reset values on that edge.

Optional Feature:
- Macro: WALL_CLOCK_ALARM_SNOOZE_LIMIT_EN.
- Defined:
  - A 2-bit snz_used counter increments on each RING->SNOOZE transition.
  - Once snz_used==3, snooze in RING is ignored; ring continues until stop or timeout.
  - snz_used clears on entry to IDLE and on reset.
- Undefined: unlimited snoozes; no snz_used register.

Decomposition:
- Shared package clock_pkg:
  - alarm state enum (IDLE, RING, SNOOZE).
  - BCD constants: HH_RESET=8'h12, MAX_MIN=8'h59, MAX_HH=8'h12, MIN_HH=8'h01.
  - SECS_PER_MIN=60.
- Sub-module bcd_time_check: combinational valid-hour/valid-minute checker. Also reusable for a future clock time-set stage.

Test Plan:
- Reset, then set_alarm 06:30 AM (8'h06, 8'h30, 0); clock runs from 06:29:58 AM -> ring rises 1 cycle after clock shows 06:30:00 AM; no ring at 06:30:00 PM with arm=1 and alarm AM.
- Ring, no input -> ring falls on the 60th `ena` after rise; no retrigger while ss advances within 06:30.
- Ring, snooze pulse -> snoozing=1, ring=0; after 540 `ena` ticks ring=1 again; stop -> IDLE, both outputs 0.
- set_alarm with set_hh=8'h13, then with set_mm=8'h5A, then with set_hh=8'h00 -> set_err pulses each time; al_hh/al_mm stay 8'h06/8'h30.
- Alarm 12:00 AM, clock wraps 11:59:59 PM -> 12:00:00 AM -> ring; same cycle stop+snooze -> IDLE (stop wins); arm dropped mid-snooze -> IDLE next cycle.
- With WALL_CLOCK_ALARM_SNOOZE_LIMIT_EN: fourth snooze pulse in RING ignored, ring stays 1; without the macro, the fourth snooze enters SNOOZE.
